// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
//   Micro-sequencer that owns the ports of a 4 x WIDTH single-write /
//   dual-read register file. It accepts one instruction at a time over a
//   valid/ready handshake, reads the two source registers, evaluates a
//   WIDTH-bit ALU (ADD / SUB / AND) and writes the result back. LDI writes
//   the immediate directly and skips the read/execute steps.
//
//   Build option:
//     REGSEQ_FASTPATH_EN  - drop the EXEC state; the ALU works straight off
//                           the RF read data during READ, so an ALU op
//                           writes one cycle earlier. LDI timing is the same.
//
//   Ports:
//     clk, reset           clock, asynchronous active-low reset
//     instr_valid/ready    instruction handshake (ready = sequencer idle)
//     instr_op/rd/rs1/rs2  opcode (00 LDI, 01 ADD, 10 SUB, 11 AND), regs
//     instr_imm            LDI immediate
//     rf_we, rf_addr_in,   RF write port (we high for one WRITE cycle)
//     rf_data
//     rf_addr_out1/2       RF read addresses (driven in READ)
//     rf_out1/2            RF combinational read data
//     busy                 instruction in flight
//     done                 one-cycle pulse after the RF write edge
//     flag_zero/carry      last ALU result == 0 / ADD carry, SUB borrow
// ---------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [1:0]       instr_rd,
    input  logic [1:0]       instr_rs1,
    input  logic [1:0]       instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic             rf_we,
    output logic [1:0]       rf_addr_in,
    output logic [1:0]       rf_addr_out1,
    output logic [1:0]       rf_addr_out2,
    output logic [WIDTH-1:0] rf_data,
    input  logic [WIDTH-1:0] rf_out1,
    input  logic [WIDTH-1:0] rf_out2,
    output logic             busy,
    output logic             done,
    output logic             flag_zero,
    output logic             flag_carry
);

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [1:0]       rd_q;
    logic             accept;
    logic             load_result;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH:0]   alu_wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    assign accept      = instr_valid && (state == IDLE);
    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    // Combinational from state so an async reset drops the write enable
    // immediately, before any RF edge can sample it.
    assign rf_we       = (state == WRITE);

`ifdef REGSEQ_FASTPATH_EN
    // ALU sits directly behind the RF read ports; result captured at the
    // end of READ.
    assign alu_a       = rf_out1;
    assign alu_b       = rf_out2;
    assign load_result = (state == READ);
`else
    logic [WIDTH-1:0] opa_q, opb_q;

    // Operands are latched at the end of READ, so rd == rs1/rs2 is safe:
    // the RF write only happens two states later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state == READ) begin
            opa_q <= rf_out1;
            opb_q <= rf_out2;
        end
    end

    assign alu_a       = opa_q;
    assign alu_b       = opb_q;
    assign load_result = (state == EXEC);
`endif

    // ALU: one extra bit carries the ADD carry-out; for SUB the same bit is
    // the borrow (set iff a < b unsigned).
    always_comb begin
        alu_wide = '0;
        case (op_q)
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
            default: alu_wide = '0;
        endcase
    end

    assign alu_res   = alu_wide[WIDTH-1:0];
    assign alu_carry = alu_wide[WIDTH];

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (instr_op == OP_LDI) ? WRITE : READ;
            end
`ifdef REGSEQ_FASTPATH_EN
            READ:  state_nxt = WRITE;
`else
            READ:  state_nxt = EXEC;
`endif
            EXEC:  state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. Read addresses and write address/data are loaded
    // only when entering the state that uses them and hold otherwise.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= OP_LDI;
            rd_q         <= '0;
            rf_addr_in   <= '0;
            rf_addr_out1 <= '0;
            rf_addr_out2 <= '0;
            rf_data      <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == WRITE);

            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                if (instr_op == OP_LDI) begin
                    // LDI goes straight to WRITE; flags are left alone.
                    rf_addr_in <= instr_rd;
                    rf_data    <= instr_imm;
                end else begin
                    rf_addr_out1 <= instr_rs1;
                    rf_addr_out2 <= instr_rs2;
                end
            end

            if (load_result) begin
                rf_addr_in <= rd_q;
                rf_data    <= alu_res;
                flag_zero  <= (alu_res == '0);
                flag_carry <= alu_carry;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

    localparam int WIDTH = 8;
`ifdef REGSEQ_FASTPATH_EN
    localparam int LAT = 1;   // cycles from READ to WRITE
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid;
    logic             instr_ready;
    logic [1:0]       instr_op, instr_rd, instr_rs1, instr_rs2;
    logic [WIDTH-1:0] instr_imm;
    logic             rf_we;
    logic [1:0]       rf_addr_in, rf_addr_out1, rf_addr_out2;
    logic [WIDTH-1:0] rf_data, rf_out1, rf_out2;
    logic             busy, done, flag_zero, flag_carry;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int w0;

    // Register file model: combinational reads, write on rising edge.
    logic [WIDTH-1:0] rf_mem [4] = '{default: '0};
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_addr_in] <= rf_data;
            we_cnt             <= we_cnt + 1;
        end
    end
    assign rf_out1 = rf_mem[rf_addr_out1];
    assign rf_out2 = rf_mem[rf_addr_out2];

    always #5 clk = ~clk;

    regfile_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .rf_we(rf_we), .rf_addr_in(rf_addr_in),
        .rf_addr_out1(rf_addr_out1), .rf_addr_out2(rf_addr_out2),
        .rf_data(rf_data), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .busy(busy), .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and take the accept edge; returns #1 after it.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [WIDTH-1:0] imm);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_imm = imm; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] rd, input logic [WIDTH-1:0] imm, input string tag);
        chk({tag, "_ready_pre"}, instr_ready, 1);
        issue(2'b00, rd, 2'd0, 2'd0, imm);
        chk({tag, "_we"}, rf_we, 1);
        chk({tag, "_addr_in"}, rf_addr_in, rd);
        chk({tag, "_data"}, rf_data, imm);
        chk({tag, "_ready"}, instr_ready, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_we_off"}, rf_we, 0);
        chk({tag, "_rf"}, rf_mem[rd], imm);
    endtask

    task automatic alu(input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [WIDTH-1:0] exp_data, input logic exp_z,
                       input logic exp_c, input string tag);
        chk({tag, "_ready_pre"}, instr_ready, 1);
        issue(op, rd, rs1, rs2, 8'hA5);
        chk({tag, "_rd_addr1"}, rf_addr_out1, rs1);
        chk({tag, "_rd_addr2"}, rf_addr_out2, rs2);
        chk({tag, "_read_we"}, rf_we, 0);
        chk({tag, "_read_ready"}, instr_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        repeat (LAT - 1) begin
            tick();
            chk({tag, "_exec_we"}, rf_we, 0);
            chk({tag, "_exec_ready"}, instr_ready, 0);
        end
        tick();
        chk({tag, "_we"}, rf_we, 1);
        chk({tag, "_addr_in"}, rf_addr_in, rd);
        chk({tag, "_data"}, rf_data, exp_data);
        chk({tag, "_zero"}, flag_zero, exp_z);
        chk({tag, "_carry"}, flag_carry, exp_c);
        chk({tag, "_done_early"}, done, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_we_off"}, rf_we, 0);
        chk({tag, "_ready_post"}, instr_ready, 1);
        chk({tag, "_rf"}, rf_mem[rd], exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a valid LDI pending: nothing must be accepted.
        reset = 1'b0; instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 2'd1;
        instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h2A;
        tick(); tick();
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", flag_zero, 0);
        chk("rst_carry", flag_carry, 0);
        chk("rst_addr_in", rf_addr_in, 0);
        chk("rst_addr_out1", rf_addr_out1, 0);
        chk("rst_addr_out2", rf_addr_out2, 0);
        chk("rst_data", rf_data, 0);
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_no_accept_busy", busy, 0);
        chk("rst_no_write", we_cnt, 0);

        // LDIs and first ADD
        ldi(2'd1, 8'h2A, "ldi1");
        ldi(2'd2, 8'h15, "ldi2");
        chk("ldi_flags_z", flag_zero, 0);
        chk("ldi_flags_c", flag_carry, 0);
        alu(2'b01, 2'd3, 2'd1, 2'd2, 8'h3F, 1'b0, 1'b0, "add_3f");

        // Flag edges
        ldi(2'd0, 8'hFF, "ldi_ff");
        ldi(2'd1, 8'h01, "ldi_01");
        alu(2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1, "add_wrap");
        ldi(2'd0, 8'h05, "ldi_05");
        ldi(2'd1, 8'h07, "ldi_07");
        alu(2'b10, 2'd3, 2'd0, 2'd1, 8'hFE, 1'b0, 1'b1, "sub_borrow");
        ldi(2'd0, 8'hF0, "ldi_f0");
        ldi(2'd1, 8'h0F, "ldi_0f");
        alu(2'b11, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 1'b0, "and_zero");
        ldi(2'd1, 8'h2A, "ldi_2a");
        chk("ldi_keeps_zero", flag_zero, 1);
        chk("ldi_keeps_carry", flag_carry, 0);
        alu(2'b01, 2'd1, 2'd1, 2'd1, 8'h54, 1'b0, 1'b0, "add_self");

        // Back-to-back with valid held and fields changed mid-flight.
        ldi(2'd2, 8'h10, "ldi_10");
        w0 = we_cnt;
        instr_op = 2'b01; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        instr_valid = 1'b1;
        tick();
        instr_op = 2'b11; instr_rd = 2'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        instr_imm = 8'hFF;
        chk("b2b_read_ready", instr_ready, 0);
        chk("b2b_rd_addr1", rf_addr_out1, 1);
        chk("b2b_rd_addr2", rf_addr_out2, 2);
        repeat (LAT - 1) begin
            tick();
            chk("b2b_exec_ready", instr_ready, 0);
        end
        tick();
        chk("b2b_write_ready", instr_ready, 0);
        chk("b2b_we", rf_we, 1);
        chk("b2b_addr_in", rf_addr_in, 3);
        chk("b2b_data", rf_data, 8'h64);
        tick();
        chk("b2b_done", done, 1);
        chk("b2b_done_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        chk("b2b2_busy", busy, 1);
        chk("b2b2_done_off", done, 0);
        chk("b2b2_rd_addr1", rf_addr_out1, 1);
        repeat (LAT) tick();
        chk("b2b2_we", rf_we, 1);
        chk("b2b2_addr_in", rf_addr_in, 0);
        chk("b2b2_data", rf_data, 8'h10);
        chk("b2b2_zero", flag_zero, 0);
        chk("b2b2_carry", flag_carry, 0);
        tick();
        chk("b2b2_done", done, 1);
        chk("b2b_we_pulses", we_cnt - w0, 2);
        chk("b2b_rf3", rf_mem[3], 8'h64);
        chk("b2b_rf0", rf_mem[0], 8'h10);

        // Reset during EXEC (WRITE in the fast build) of an ADD.
        ldi(2'd0, 8'hFF, "ldi_ff2");
        ldi(2'd1, 8'h01, "ldi_012");
        alu(2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1, "add_wrap2");
        w0 = we_cnt;
        issue(2'b01, 2'd3, 2'd0, 2'd1, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_we", rf_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_zero", flag_zero, 0);
        chk("abort_carry", flag_carry, 0);
        tick(); tick();
        chk("abort_no_write", we_cnt - w0, 0);
        chk("abort_rf3", rf_mem[3], 8'h64);
        chk("abort_done2", done, 0);
        reset = 1'b1;
        tick();
        chk("abort_post_done", done, 0);
        chk("abort_post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
